// File: rtl/image_write.sv
// Captures a pixel-pair video stream into a frame buffer, then streams it out as a 24-bit BMP file.
module image_write #(
    parameter int unsigned WIDTH     = 512,
    parameter int unsigned HEIGHT    = 512,
    parameter int unsigned HDR_BYTES = 54
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       VSYNC,
    input  logic       HSYNC,
    input  logic [7:0] DATA_R0,
    input  logic [7:0] DATA_G0,
    input  logic [7:0] DATA_B0,
    input  logic [7:0] DATA_R1,
    input  logic [7:0] DATA_G1,
    input  logic [7:0] DATA_B1,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       frame_done
);

    // One buffer word holds one pixel pair: 6 consecutive BMP bytes (B0 G0 R0 B1 G1 R1).
    localparam int unsigned NBEATS     = WIDTH * HEIGHT / 2;
    localparam int unsigned NWORDS     = NBEATS;
    localparam int unsigned PIX_BYTES  = WIDTH * HEIGHT * 3;
    localparam int unsigned FILE_BYTES = HDR_BYTES + PIX_BYTES;
    localparam int unsigned AW         = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned BEAT_W     = ($clog2(NBEATS + 1) > 18) ? $clog2(NBEATS + 1) : 18;
    localparam int unsigned CNT_W      = $clog2(FILE_BYTES + 1);
    localparam int unsigned ROW_W      = 10;
    localparam int unsigned COL_W      = 11;

    localparam logic [31:0] FILE_SIZE  = 32'(FILE_BYTES);
    localparam logic [31:0] DATA_OFS   = 32'(HDR_BYTES);
    localparam logic [31:0] INFO_SIZE  = 32'd40;
    localparam logic [31:0] IMG_W      = 32'(WIDTH);
    localparam logic [31:0] IMG_H      = 32'(HEIGHT);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        HEADER,
        PIXELS,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [BEAT_W-1:0] beat_q;
    logic [CNT_W-1:0]  out_cnt_q;      // index of the next file byte to load into out_data
    logic [2:0]        sel_q;          // byte lane within cur_word_q
    logic [AW-1:0]     rd_idx_q;       // buffer word being prefetched into mem_q
    logic [1:0]        pf_q;           // initial prefetch progress during HEADER
    logic [47:0]       cur_word_q;
    logic [47:0]       mem_q;
    logic [47:0]       fb [NWORDS];

    logic          beat_c;
    logic          last_beat_c;
    logic          xfer_c;
    logic          is_hdr_c;
    logic          load_c;
    logic [AW-1:0] wr_idx_c;
    logic [47:0]   wr_word_c;
    logic [7:0]    pix_byte_c;
    logic [7:0]    load_byte_c;

    // BMP header byte at a given file offset; unlisted offsets are zero.
    function automatic logic [7:0] hdr_byte(input logic [CNT_W-1:0] idx);
        logic [31:0] off;
        off      = 32'(idx);
        hdr_byte = 8'h00;
        if (off == 32'd0)
            hdr_byte = 8'h42;
        else if (off == 32'd1)
            hdr_byte = 8'h4D;
        else if (off >= 32'd2 && off < 32'd6)
            hdr_byte = 8'(FILE_SIZE >> (8 * (off - 32'd2)));
        else if (off >= 32'd10 && off < 32'd14)
            hdr_byte = 8'(DATA_OFS >> (8 * (off - 32'd10)));
        else if (off >= 32'd14 && off < 32'd18)
            hdr_byte = 8'(INFO_SIZE >> (8 * (off - 32'd14)));
        else if (off >= 32'd18 && off < 32'd22)
            hdr_byte = 8'(IMG_W >> (8 * (off - 32'd18)));
        else if (off >= 32'd22 && off < 32'd26)
            hdr_byte = 8'(IMG_H >> (8 * (off - 32'd22)));
        else if (off == 32'd26)
            hdr_byte = 8'd1;
        else if (off == 32'd28)
            hdr_byte = 8'd24;
    endfunction

    assign beat_c      = (state_q == CAPTURE) && HSYNC;
    assign last_beat_c = beat_c && (beat_q == BEAT_W'(NBEATS - 1));
    assign xfer_c      = out_valid && out_ready;
    assign is_hdr_c    = out_cnt_q < CNT_W'(HDR_BYTES);
    assign load_c      = ((state_q == HEADER) || (state_q == PIXELS))
                         && (!out_valid || out_ready)
                         && (out_cnt_q != CNT_W'(FILE_BYTES))
                         && (is_hdr_c || (pf_q == 2'd2));

    // Bottom-up row order; the pair index is the BMP pixel index halved.
    assign wr_idx_c  = AW'((32'(HEIGHT - 1) - 32'(row_q)) * 32'(WIDTH / 2) + 32'(col_q >> 1));
    assign wr_word_c = {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};

    // Select the next byte to present: header constant or buffered pixel byte.
    always_comb begin
        pix_byte_c = 8'h00;
        case (sel_q)
            3'd0:    pix_byte_c = cur_word_q[7:0];
            3'd1:    pix_byte_c = cur_word_q[15:8];
            3'd2:    pix_byte_c = cur_word_q[23:16];
            3'd3:    pix_byte_c = cur_word_q[31:24];
            3'd4:    pix_byte_c = cur_word_q[39:32];
            3'd5:    pix_byte_c = cur_word_q[47:40];
            default: pix_byte_c = 8'h00;
        endcase
        load_byte_c = is_hdr_c ? hdr_byte(out_cnt_q) : pix_byte_c;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (VSYNC) state_d = CAPTURE;
            CAPTURE: if (last_beat_c) state_d = HEADER;
            HEADER:  if (xfer_c && (out_cnt_q == CNT_W'(HDR_BYTES))) state_d = PIXELS;
            PIXELS:  if (xfer_c && out_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with registered status outputs.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy       <= (state_d != IDLE);
            frame_done <= (state_d == DONE);
        end
    end

    // Frame buffer: pair writes during capture, one-cycle registered read.
    always_ff @(posedge HCLK) begin
        if (beat_c)
            fb[wr_idx_c] <= wr_word_c;
        mem_q <= fb[rd_idx_q];
    end

    // Capture counters, read prefetch and the output byte register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            row_q      <= '0;
            col_q      <= '0;
            beat_q     <= '0;
            out_cnt_q  <= '0;
            sel_q      <= '0;
            rd_idx_q   <= '0;
            pf_q       <= '0;
            cur_word_q <= '0;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            if ((state_q == IDLE) && VSYNC) begin
                row_q     <= '0;
                col_q     <= '0;
                beat_q    <= '0;
                out_cnt_q <= '0;
                sel_q     <= '0;
                rd_idx_q  <= '0;
                pf_q      <= '0;
            end

            if (beat_c) begin
                beat_q <= beat_q + BEAT_W'(1);
                if (col_q == COL_W'(WIDTH - 2)) begin
                    col_q <= '0;
                    row_q <= row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(2);
                end
            end

            // Word 0 lands in cur_word_q and word 1 in mem_q while the header drains.
            if ((state_q == HEADER) && (pf_q != 2'd2)) begin
                pf_q <= pf_q + 2'd1;
                if (pf_q == 2'd1) begin
                    cur_word_q <= mem_q;
                    rd_idx_q   <= AW'(1);
                end
            end

            if (load_c) begin
                out_valid <= 1'b1;
                out_data  <= load_byte_c;
                out_last  <= (out_cnt_q == CNT_W'(FILE_BYTES - 1));
                out_cnt_q <= out_cnt_q + CNT_W'(1);
                if (!is_hdr_c) begin
                    if (sel_q == 3'd5) begin
                        sel_q      <= '0;
                        cur_word_q <= mem_q;
                        if (rd_idx_q != AW'(NWORDS - 1))
                            rd_idx_q <= rd_idx_q + AW'(1);
                    end else begin
                        sel_q <= sel_q + 3'd1;
                    end
                end
            end else if (xfer_c) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
